prince_sbox_inv_serial: RTL

// - Inverse S-box layer (S^-1) of the PRINCE backward rounds; consumes the 64-bit state produced by
//   the inverse linear layer (M^-1) and yields the substituted state for the next key/RC addition.
// - Area-reduced: LANES nibbles substituted per clock, state held in an internal rotating register.
// - valid/ready handshakes on both sides so the round controller can stall either end.
//

---
 rtl/prince_pkg.sv | 22 ++
 rtl/prince_sbox_inv_nib.sv | 11 +
 rtl/prince_sbox_inv_serial.sv | 108 ++++++++++
 3 files changed

// File: rtl/prince_pkg.sv
// Shared PRINCE definitions: inverse S-box table, serial FSM state encoding and state geometry.
package prince_pkg;

    localparam int NIBBLES = 16;

    // S^-1 indexed by the input nibble value.
    localparam logic [3:0] SBOX_INV [NIBBLES] = '{
        4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox_inv_lookup(input logic [3:0] x);
        return SBOX_INV[x];
    endfunction

endpackage

// File: rtl/prince_sbox_inv_nib.sv
// Single-nibble inverse PRINCE S-box, purely combinational.
module prince_sbox_inv_nib
    import prince_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] sub
);

    assign sub = sbox_inv_lookup(nib);

endmodule

// File: rtl/prince_sbox_inv_serial.sv
// Serial PRINCE S^-1 layer: LANES nibbles per clock taken from the top of a rotating 64-bit
// register, with valid/ready on both sides and no idle bubble between back-to-back blocks.
module prince_sbox_inv_serial
    import prince_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);

    localparam int NGRP = (LANES > 0) ? (NIBBLES / LANES) : 1;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int SW   = 4 * LANES;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    generate
        if (LANES < 1 || LANES > NIBBLES || (NIBBLES % LANES) != 0) begin : g_bad_lanes
            $error("prince_sbox_inv_serial: LANES=%0d must divide 16", LANES);
        end
    endgenerate

    state_t         state_reg, state_next;
    logic [GW-1:0]  grp_cnt_reg, grp_cnt_next;
    logic [63:0]    sreg_reg, sreg_next;
    logic [SW-1:0]  top_nibs;
    logic [SW-1:0]  sub_nibs;
    logic [63:0]    rot_val;

    assign top_nibs = sreg_reg[63 -: SW];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            prince_sbox_inv_nib u_nib (
                .nib (top_nibs[4*gi +: 4]),
                .sub (sub_nibs[4*gi +: 4])
            );
        end

        // Substituted top group re-enters at the bottom, so NGRP steps restore nibble order.
        if (LANES == NIBBLES) begin : g_rot_full
            assign rot_val = sub_nibs;
        end else begin : g_rot_part
            assign rot_val = {sreg_reg[63-SW:0], sub_nibs};
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        grp_cnt_next = grp_cnt_reg;
        sreg_next    = sreg_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sreg_next    = data_in;
                    grp_cnt_next = '0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                sreg_next    = rot_val;
                grp_cnt_next = grp_cnt_reg + GW'(1);
                if (grp_cnt_reg == LAST_GRP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        sreg_next    = data_in;
                        grp_cnt_next = '0;
                        state_next   = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            grp_cnt_reg <= '0;
            sreg_reg    <= 64'h0;
        end else begin
            state_reg   <= state_next;
            grp_cnt_reg <= grp_cnt_next;
            sreg_reg    <= sreg_next;
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held even though the state reads IDLE.
    assign in_ready  = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign data_out  = sreg_reg;

endmodule
